led_blinker: RTL and testbench

LED_BLINKER -- requirements
Module: led_blinker

---
 rtl/led_blinker_pkg.sv | 23 ++
 rtl/led_blinker_phase_timer.sv | 32 +++
 rtl/led_blinker.sv | 181 ++++++++++++++++++
 tb/tb_led_blinker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_blinker_pkg.sv
// Shared definitions for the LED blink sequencer.
//   state_t            : FSM state encoding (IDLE/ON/OFF)
//   DEFAULT_*_CYCLES   : default phase lengths in clock periods
//   timer_width()      : bit width for a phase down-counter that must hold
//                        max_cycles-1 without wrapping
package led_blinker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_ON_CYCLES  = 5000000;
    localparam int unsigned DEFAULT_OFF_CYCLES = 5000000;

    // The timer is loaded with (cycles - 1) and counts down to zero, so it
    // only has to represent values up to max_cycles - 1.
    function automatic int unsigned timer_width(input int unsigned max_cycles);
        return (max_cycles > 1) ? $clog2(max_cycles) : 1;
    endfunction

endpackage

// File: rtl/led_blinker_phase_timer.sv
// Loadable down-counter used to time the ON and OFF phases.
//   clock        : system clock
//   reset        : asynchronous, active-high
//   load_i       : load strobe, takes priority over counting
//   load_value_i : value loaded on load_i
//   expired_o    : high while the count is zero
// The counter saturates at zero; it never wraps.
module phase_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/led_blinker.sv
// LED blink sequencer: on a trigger, blinks the LED blinkCount times
// (ON_CYCLES high, OFF_CYCLES low per blink), with one pending request slot.
//   clock      : system clock, rising edge
//   reset      : asynchronous, active-high
//   trigger    : single-cycle request pulse
//   blinkCount : blinks requested, sampled with trigger
//   abort      : synchronous cancel of active and pending sequences
//   led        : registered blink output
//   busy       : registered, high while a sequence runs
//   done       : registered single-cycle completion pulse
//   overrun    : registered single-cycle pulse when a request is dropped
//
// state | meaning
// IDLE  | no sequence running
// ON    | LED high, timing the ON phase
// OFF   | LED low, timing the OFF phase (also the one-cycle hop for a
//       | chained zero-count request)
module led_blinker
    import led_blinker_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int unsigned OFF_CYCLES = DEFAULT_OFF_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [3:0] blinkCount,
    input  logic       abort,
    output logic       led,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW         = timer_width(MAX_CYCLES);
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] remaining_q, remaining_d;
    logic       pend_valid_q, pend_valid_d;
    logic [3:0] pend_count_q, pend_count_d;
    logic       led_q, led_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       overrun_q, overrun_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_expired;
    logic          complete;
    logic [3:0]    next_count;

    phase_timer #(.WIDTH(TW)) u_phase_timer (
        .clock        (clock),
        .reset        (reset),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .expired_o    (tmr_expired)
    );

    // Last OFF cycle of the last blink (or the hop of a zero-count chain).
    assign complete   = (state_q == ST_OFF) && tmr_expired && (remaining_q <= 4'd1);
    assign next_count = pend_valid_q ? pend_count_q : blinkCount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            remaining_q  <= 4'd0;
            pend_valid_q <= 1'b0;
            pend_count_q <= 4'd0;
            led_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            pend_valid_q <= pend_valid_d;
            pend_count_q <= pend_count_d;
            led_q        <= led_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        pend_valid_d = pend_valid_q;
        pend_count_d = pend_count_q;
        tmr_load     = 1'b0;
        tmr_value    = '0;

        if (abort) begin
            state_d      = ST_IDLE;
            remaining_d  = 4'd0;
            pend_valid_d = 1'b0;
            pend_count_d = 4'd0;
            tmr_load     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger && (blinkCount != 4'd0)) begin
                        state_d     = ST_ON;
                        remaining_d = blinkCount;
                        tmr_load    = 1'b1;
                        tmr_value   = ON_LOAD;
                    end
                end
                ST_ON: begin
                    if (tmr_expired) begin
                        state_d   = ST_OFF;
                        tmr_load  = 1'b1;
                        tmr_value = OFF_LOAD;
                    end
                end
                ST_OFF: begin
                    if (tmr_expired && (remaining_q > 4'd1)) begin
                        state_d     = ST_ON;
                        remaining_d = remaining_q - 4'd1;
                        tmr_load    = 1'b1;
                        tmr_value   = ON_LOAD;
                    end else if (complete) begin
                        if (pend_valid_q || trigger) begin
                            pend_valid_d = 1'b0;
                            tmr_load     = 1'b1;
                            if (next_count != 4'd0) begin
                                state_d     = ST_ON;
                                remaining_d = next_count;
                                tmr_value   = ON_LOAD;
                            end else begin
                                // Zero-count chain: spend one busy cycle in
                                // OFF with an expired timer so it completes
                                // (with its own done pulse) on the next edge.
                                state_d     = ST_OFF;
                                remaining_d = 4'd0;
                            end
                        end else begin
                            state_d     = ST_IDLE;
                            remaining_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    remaining_d = 4'd0;
                end
            endcase

            // A request arriving mid-sequence goes to the empty pending slot;
            // on the completion edge it was already started directly above.
            if ((state_q != ST_IDLE) && trigger && !pend_valid_q && !complete) begin
                pend_valid_d = 1'b1;
                pend_count_d = blinkCount;
            end
        end
    end

    always_comb begin
        led_d     = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        if (!abort) begin
            led_d     = (state_d == ST_ON);
            busy_d    = (state_d != ST_IDLE);
            done_d    = complete ||
                        ((state_q == ST_IDLE) && trigger && (blinkCount == 4'd0));
            overrun_d = (state_q != ST_IDLE) && trigger && pend_valid_q;
        end
    end

    assign led     = led_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_led_blinker.sv
module tb_led_blinker;

    localparam int ON_C  = 3;
    localparam int OFF_C = 2;
    localparam int PER_C = ON_C + OFF_C;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic [3:0] blinkCount = 4'd0;
    logic       abort = 1'b0;
    logic       led, busy, done, overrun;

    int n_cmp = 0;
    int n_err = 0;

    led_blinker #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
        .clock      (clock),
        .reset      (reset),
        .trigger    (trigger),
        .blinkCount (blinkCount),
        .abort      (abort),
        .led        (led),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // Reference model: a sequence of N blinks started at edge s occupies
    // edges s .. s+N*PER_C; LED is high for the first ON_C cycles of each
    // period. A chained zero-count request occupies one busy cycle.
    int  m_t;
    bit  m_active;
    int  m_start, m_n, m_len;
    int  m_pend[$];
    bit  e_led, e_busy, e_done, e_ovr;

    function automatic void model_reset();
        m_active = 0;
        m_pend.delete();
        e_led = 0; e_busy = 0; e_done = 0; e_ovr = 0;
    endfunction

    function automatic void model_start(input int n);
        m_active = 1;
        m_start  = m_t;
        m_n      = n;
        m_len    = (n == 0) ? 1 : n * PER_C;
    endfunction

    function automatic void model_step(input bit trg, input int cnt, input bit ab);
        e_done = 0;
        e_ovr  = 0;
        if (ab) begin
            m_active = 0;
            m_pend.delete();
        end else if (m_active && (m_t - m_start == m_len)) begin
            e_done = 1;
            if (m_pend.size() > 0) begin
                model_start(m_pend.pop_front());
                if (trg) e_ovr = 1;
            end else if (trg) begin
                model_start(cnt);
            end else begin
                m_active = 0;
            end
        end else if (m_active) begin
            if (trg) begin
                if (m_pend.size() == 0) m_pend.push_back(cnt);
                else e_ovr = 1;
            end
        end else if (trg) begin
            if (cnt == 0) e_done = 1;
            else model_start(cnt);
        end
        e_busy = m_active;
        e_led  = m_active && (m_n > 0) && (((m_t - m_start) % PER_C) < ON_C);
        m_t++;
    endfunction

    task automatic tick(input logic trg, input logic [3:0] cnt, input logic ab);
        trigger    = trg;
        blinkCount = cnt;
        abort      = ab;
        @(posedge clock);
        model_step(trg, int'(cnt), ab);
        #1;
        trigger = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({led, busy, done, overrun} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: got %b want 0000", {led, busy, done, overrun});
        end
        reset = 1'b0;
        model_reset();
        m_t = 0;
    endtask

    task automatic test_single();
        for (int e = 0; e < 12; e++) begin
            tick(e == 0, 4'd2, 1'b0);
            n_cmp++;
            if ({led, busy, done, overrun} !==
                {(e < 3) || (e >= 5 && e < 8), e < 10, e == 10, 1'b0}) begin
                n_err++;
                $display("FAIL single e=%0d: got %b want %b", e, {led, busy, done, overrun},
                         {(e < 3) || (e >= 5 && e < 8), e < 10, e == 10, 1'b0});
            end
        end
    endtask

    task automatic test_zero_count();
        for (int e = 0; e < 3; e++) begin
            tick(e == 0, 4'd0, 1'b0);
            n_cmp++;
            if ({led, busy, done, overrun} !== {1'b0, 1'b0, e == 0, 1'b0}) begin
                n_err++;
                $display("FAIL zero_count e=%0d: got %b want %b", e,
                         {led, busy, done, overrun}, {1'b0, 1'b0, e == 0, 1'b0});
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int e = 0; e < 12; e++) begin
            tick((e == 0) || (e == 2), 4'd1, 1'b0);
            n_cmp++;
            if ({led, busy, done, overrun} !==
                {(e < 3) || (e >= 5 && e < 8), e < 10, (e == 5) || (e == 10), 1'b0}) begin
                n_err++;
                $display("FAIL back_to_back e=%0d: got %b want %b", e, {led, busy, done, overrun},
                         {(e < 3) || (e >= 5 && e < 8), e < 10, (e == 5) || (e == 10), 1'b0});
            end
        end
    endtask

    task automatic test_overrun();
        logic [3:0] cnt;
        logic       exp_led;
        for (int e = 0; e < 23; e++) begin
            cnt = (e == 0) ? 4'd3 : (e == 1) ? 4'd1 : 4'd2;
            tick(e <= 2, cnt, 1'b0);
            exp_led = (e < 15) ? ((e % 5) < 3) : ((e < 20) && (((e - 15) % 5) < 3));
            n_cmp++;
            if ({led, busy, done, overrun} !==
                {exp_led, e < 20, (e == 15) || (e == 20), e == 2}) begin
                n_err++;
                $display("FAIL overrun e=%0d: got %b want %b", e, {led, busy, done, overrun},
                         {exp_led, e < 20, (e == 15) || (e == 20), e == 2});
            end
        end
    endtask

    task automatic test_abort();
        for (int e = 0; e < 20; e++) begin
            tick((e == 0) || (e == 6), (e == 0) ? 4'd4 : 4'd2, e == 6);
            if (e >= 6) begin
                n_cmp++;
                if ({led, busy, done, overrun} !== 4'b0000) begin
                    n_err++;
                    $display("FAIL abort e=%0d: got %b want 0000", e, {led, busy, done, overrun});
                end
            end
        end
    endtask

    task automatic test_reset_mid_on();
        tick(1'b1, 4'd3, 1'b0);
        tick(1'b0, 4'd0, 1'b0);
        n_cmp++;
        if (led !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_on_pre: led got %b want 1", led);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({led, busy, done, overrun} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_on_async: got %b want 0000", {led, busy, done, overrun});
        end
        #2 reset = 1'b0;
        model_reset();
        for (int e = 0; e < 7; e++) begin
            tick(e == 0, 4'd1, 1'b0);
            n_cmp++;
            if ({led, busy, done, overrun} !== {e < 3, e < 5, e == 5, 1'b0}) begin
                n_err++;
                $display("FAIL reset_mid_on_seq e=%0d: got %b want %b", e,
                         {led, busy, done, overrun}, {e < 3, e < 5, e == 5, 1'b0});
            end
        end
    endtask

    task automatic test_random();
        logic       trg, ab;
        logic [3:0] cnt;
        tick(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            trg = ($urandom_range(0, 5) == 0);
            ab  = ($urandom_range(0, 59) == 0);
            cnt = 4'($urandom_range(0, 3));
            tick(trg, cnt, ab);
            n_cmp++;
            if ({led, busy, done, overrun} !== {e_led, e_busy, e_done, e_ovr}) begin
                n_err++;
                $display("FAIL random i=%0d: got %b want %b", i,
                         {led, busy, done, overrun}, {e_led, e_busy, e_done, e_ovr});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_count();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_mid_on();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
